// File: rtl/toysram_pkg.sv
// Shared constants, write-FSM encoding and the wordline decoder for the
// 32x12 toysram local control stage. Wordline vectors are MSB-first: bit [r] drives row r.
package toysram_pkg;

    localparam int TOYSRAM_ROWS  = 32;
    localparam int TOYSRAM_WIDTH = 12;
    localparam int TOYSRAM_ADR_W = 5;

    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_SETUP = 2'd1;
    localparam logic [1:0] WR_PULSE = 2'd2;
    localparam logic [1:0] WR_HOLD  = 2'd3;

    // Addresses at or beyond the row count decode to no wordline at all.
    function automatic logic [0:TOYSRAM_ROWS-1] decode_onehot(input logic [TOYSRAM_ADR_W-1:0] adr);
        logic [0:TOYSRAM_ROWS-1] wl;
        wl = '0;
        for (int r = 0; r < TOYSRAM_ROWS; r++) begin
            if (int'(adr) == r) wl[r] = 1'b1;
        end
        return wl;
    endfunction

endpackage

// File: rtl/toysram_32x12_ctl_if.sv
// Request/response side of the toysram control stage: two read ports and one write port.
interface toysram_32x12_ctl_if
    import toysram_pkg::*;
#(
    parameter int WIDTH = TOYSRAM_WIDTH,
    parameter int ADR_W = TOYSRAM_ADR_W
);
    logic             rd0_val;
    logic [ADR_W-1:0] rd0_adr;
    logic             rd0_dat_val;
    logic [WIDTH-1:0] rd0_dat;
    logic             rd1_val;
    logic [ADR_W-1:0] rd1_adr;
    logic             rd1_dat_val;
    logic [WIDTH-1:0] rd1_dat;
    logic             wr_val;
    logic             wr_rdy;
    logic [ADR_W-1:0] wr_adr;
    logic [WIDTH-1:0] wr_dat;

    modport master (
        output rd0_val, rd0_adr, rd1_val, rd1_adr, wr_val, wr_adr, wr_dat,
        input  rd0_dat_val, rd0_dat, rd1_dat_val, rd1_dat, wr_rdy
    );

    modport slave (
        input  rd0_val, rd0_adr, rd1_val, rd1_adr, wr_val, wr_adr, wr_dat,
        output rd0_dat_val, rd0_dat, rd1_dat_val, rd1_dat, wr_rdy
    );
endinterface

// File: rtl/toysram_rd_port.sv
// One read port: registered wordline drive, bitline capture a cycle later,
// and a bypass for reads that overlap the SETUP cycle of a same-row write.
module toysram_rd_port
    import toysram_pkg::*;
#(
    parameter int ROWS  = TOYSRAM_ROWS,
    parameter int WIDTH = TOYSRAM_WIDTH,
    parameter int ADR_W = TOYSRAM_ADR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_val,
    input  logic [ADR_W-1:0] req_adr,
    output logic [0:ROWS-1]  rwl,
    input  logic [WIDTH-1:0] rbl,
    input  logic             wr_setup,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             dat_val,
    output logic [WIDTH-1:0] dat
);
    logic [1:0]       vld_pipe;
    logic [ADR_W-1:0] adr_q;
    logic             in_range;
    logic             byp;

    assign in_range = int'(adr_q) < ROWS;
    // The array only commits at PULSE, so a read overlapping SETUP would see stale data.
    assign byp      = wr_setup && in_range && (wr_adr == adr_q);
    assign dat_val  = vld_pipe[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            adr_q    <= '0;
            rwl      <= '0;
            dat      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], req_val};
            if (req_val) adr_q <= req_adr;
            rwl <= req_val ? decode_onehot(req_adr) : '0;
            if (vld_pipe[0]) dat <= byp ? wr_dat : (in_range ? rbl : '0);
        end
    end

endmodule

// File: rtl/toysram_32x12_ctl.sv
// Local control stage for the 32x12 toysram subarray: two read ports and a
// setup/pulse/hold write sequencer, all wordlines and bitlines driven from flops.
module toysram_32x12_ctl
    import toysram_pkg::*;
#(
    parameter int ROWS  = TOYSRAM_ROWS,
    parameter int WIDTH = TOYSRAM_WIDTH,
    parameter int ADR_W = TOYSRAM_ADR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    toysram_32x12_ctl_if.slave        bus,
    output logic [0:ROWS-1]           RWL0,
    output logic [0:ROWS-1]           RWL1,
    output logic [0:ROWS-1]           WWL,
    output logic [WIDTH-1:0]          WBL,
    output logic [WIDTH-1:0]          WBLb,
    input  logic [WIDTH-1:0]          RBL0,
    input  logic [WIDTH-1:0]          RBL1,
    output logic                      err_multi
);
    logic [1:0]                  rd_val;
    logic [1:0][ADR_W-1:0]       rd_adr;
    logic [1:0][0:ROWS-1]        rwl;
    logic [1:0][WIDTH-1:0]       rbl;
    logic [1:0]                  rd_dat_val;
    logic [1:0][WIDTH-1:0]       rd_dat;

    logic [1:0]       state;
    logic [ADR_W-1:0] wadr_q;
    logic             accept;

    assign rd_val          = {bus.rd1_val, bus.rd0_val};
    assign rd_adr          = {bus.rd1_adr, bus.rd0_adr};
    assign rbl             = {RBL1, RBL0};
    assign RWL0            = rwl[0];
    assign RWL1            = rwl[1];
    assign bus.rd0_dat_val = rd_dat_val[0];
    assign bus.rd1_dat_val = rd_dat_val[1];
    assign bus.rd0_dat     = rd_dat[0];
    assign bus.rd1_dat     = rd_dat[1];

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd
            toysram_rd_port #(.ROWS(ROWS), .WIDTH(WIDTH), .ADR_W(ADR_W)) u_rd (
                .clk      (clk),
                .rst_n    (rst_n),
                .req_val  (rd_val[p]),
                .req_adr  (rd_adr[p]),
                .rwl      (rwl[p]),
                .rbl      (rbl[p]),
                .wr_setup (state == WR_SETUP),
                .wr_adr   (wadr_q),
                .wr_dat   (WBL),
                .dat_val  (rd_dat_val[p]),
                .dat      (rd_dat[p])
            );
        end
    endgenerate

    assign bus.wr_rdy = (state == WR_IDLE) || (state == WR_HOLD);
    assign accept     = bus.wr_val && bus.wr_rdy;

    // WBL doubles as the registered write data; WWL is raised only for the PULSE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WR_IDLE;
            wadr_q    <= '0;
            WWL       <= '0;
            WBL       <= '0;
            WBLb      <= '0;
            err_multi <= 1'b0;
        end else begin
            WWL       <= '0;
            err_multi <= err_multi | (|(WWL & (WWL - ROWS'(1))));
            case (state)
                WR_IDLE, WR_HOLD: begin
                    if (accept) begin
                        state  <= WR_SETUP;
                        wadr_q <= bus.wr_adr;
                        WBL    <= bus.wr_dat;
                        WBLb   <= ~bus.wr_dat;
                    end else begin
                        state <= WR_IDLE;
                        WBL   <= '0;
                        WBLb  <= '0;
                    end
                end
                WR_SETUP: begin
                    state <= WR_PULSE;
                    WWL   <= decode_onehot(wadr_q);
                end
                default: state <= WR_HOLD;
            endcase
        end
    end

endmodule

// File: doc/toysram_32x12_ctl.md
Name: toysram_32x12_ctl

Overview:
- Local control stage directly upstream of the 32x12 toysram subarray. Turns clocked read and write requests into subarray wordline and bitline signals, then registers the read bitline data returned by the subarray.
- Two independent read ports (0/1) drive RWL0/RWL1. One write port drives WWL/WBL/WBLb through a setup/pulse/hold sequence. The subarray latches write data on the WWL rising edge.

Parameters:
- ROWS, 32, number of wordlines; must equal the subarray row count.
- WIDTH, 12, data bits per row.
- ADR_W, 5, address width; clog2(ROWS).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous reset, active low.
- rd0_val  in  1  port-0 read request; always accepted.
- rd0_adr  in  ADR_W  port-0 row address.
- rd0_dat_val  out  1  port-0 read data valid.
- rd0_dat  out  WIDTH  port-0 read data.
- rd1_val, rd1_adr, rd1_dat_val, rd1_dat  same as port 0, for port 1.
- wr_val  in  1  write request.
- wr_rdy  out  1  write request accepted when wr_val & wr_rdy.
- wr_adr  in  ADR_W  write row address.
- wr_dat  in  WIDTH  write data.
- RWL0  out  ROWS  port-0 read wordlines; one-hot or zero.
- RWL1  out  ROWS  port-1 read wordlines; one-hot or zero.
- WWL  out  ROWS  write wordlines; one-hot or zero.
- WBL  out  WIDTH  write bitline, true polarity.
- WBLb  out  WIDTH  write bitline, complement polarity.
- RBL0  in  WIDTH  port-0 read bitlines from the subarray; positive-true.
- RBL1  in  WIDTH  port-1 read bitlines from the subarray; positive-true.
- err_multi  out  1  sticky error: more than one WWL bit seen high in a cycle.

Behaviour:
- Reset, next edge with rst_n=0:
  - RWL0/RWL1/WWL=0; WBL=0, WBLb=0 (bitlines released).
  - rd*_dat_val=0, rd*_dat=0, err_multi=0.
  - Write FSM to IDLE, so wr_rdy=1 after reset.
- Reset mid-write: WWL falls at the reset edge. Target row contents are then undefined unless the FSM was already in HOLD. Reads in flight are dropped, with no dat_val.
- Read port p, request accepted in cycle N:
  - N+1: RWLp = decode(adr) for the full cycle; all zero in cycles with no request.
  - End of N+1: RBLp captured into rdp_dat.
  - N+2: rdp_dat_val=1 for one cycle. Latency 2, throughput 1 per cycle per port.
  - rdp_dat holds its value when no read is issued.
- Both ports may read the same row in the same cycle; each returns identical data.
- Write FSM:
  - IDLE: wr_rdy=1. On accept, register adr/dat and go to SETUP.
  - SETUP: WBL=dat, WBLb=~dat, WWL=0. Go to PULSE.
  - PULSE: WBL/WBLb held; WWL[adr]=1. The array commits at this cycle's rising edge. Go to HOLD.
  - HOLD: WWL=0, bitlines held, wr_rdy=1. On accept go to SETUP with new adr/dat; otherwise go to IDLE, where WBL=WBLb=0.
- Write timing: 3 cycles from accept to commit; back-to-back throughput is one write per 3 cycles. wr_rdy=0 in SETUP and PULSE.
- Read/write collision: a read whose RWL cycle (N+1) coincides with SETUP of a write to the same row returns the registered write data instead of RBL (bypass). In PULSE or HOLD the array already holds the new data, so no bypass applies.
- Out-of-range address (>= ROWS when ROWS is not a power of two): no wordline asserted; read returns 0.
- err_multi: sticky, set if popcount(WWL)>1; cleared only by reset. This is a design-checking aid; with a correct FSM it is never set.
- Wordline outputs come directly from flops; no combinational path from request inputs to RWL/WWL.

Decomposition:
- Package toysram_pkg:
  - constants TOYSRAM_ROWS=32, TOYSRAM_WIDTH=12, TOYSRAM_ADR_W=5;
  - write FSM state encoding (IDLE/SETUP/PULSE/HOLD, 2 bits);
  - function decode_onehot(adr) returning ROWS bits.
- Sub-module toysram_rd_port, instantiated twice: request register, wordline decode, RBL capture, valid pipe, bypass mux.
- The write FSM stays in the top module.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> all WL=0, WBL=WBLb=0, wr_rdy=1, rd*_dat_val=0, err_multi=0.
- Write then read:
  - accept write adr=5, dat=0xA5C -> SETUP WBL=0xA5C, WBLb=0x5A3; PULSE WWL=1<<(31-5) (bit[5] high, MSB-first); HOLD WWL=0.
  - Then rd0 adr=5 -> RWL0[5]=1 at N+1, rd0_dat=0xA5C with dat_val at N+2.
- Dual-port read: rd0 adr=5 and rd1 adr=31 in the same cycle after writing 0xFFF to row 31 -> both valid at N+2, rd0_dat=0xA5C, rd1_dat=0xFFF.
- Back-to-back writes:
  - wr_val held with adr 0,1,2 -> accepts 3 cycles apart; wr_rdy pattern 1,0,0,1,0,0,1.
  - WWL pulses rows 0,1,2, each exactly 1 cycle; err_multi stays 0.
- Bypass: write adr=7 dat=0x123 accepted in cycle N, rd0 adr=7 in cycle N (RWL0 in SETUP) -> rd0_dat=0x123 at N+2 even with the array model returning the old value.
- Reset mid-write: assert rst_n=0 in the PULSE cycle -> at the next edge WWL=0, FSM IDLE, wr_rdy=1; a pending read produces no dat_val.
